// File: rtl/clk_div.sv
// clk_div: registered 50%-duty clock divider with fast/slow ratio select.
// Optional macro CLKDIV_SEL_SYNC_EN adds a 2-flop synchronizer on sel.
// The output is taken straight from a flop, so it cannot glitch.
module clk_div #(
  parameter int CNT_W     = 26,
  parameter int HALF_FAST = 1,
  parameter int HALF_SLOW = 4
) (
  input  logic in,
  input  logic rst,
  input  logic sel,
  output logic out
);

  // Terminal counts are held at full counter width (HALF up to 2^CNT_W fits after -1).
  localparam logic [CNT_W-1:0] TERM_FAST = CNT_W'(HALF_FAST - 1);
  localparam logic [CNT_W-1:0] TERM_SLOW = CNT_W'(HALF_SLOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             sel_e;
  logic [CNT_W-1:0] term;

`ifdef CLKDIV_SEL_SYNC_EN
  logic s1_q, s2_q;

  // Two-stage synchronizer for sel; sel_e lags sel by two edges.
  always_ff @(posedge in or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sel;
      s2_q <= s1_q;
    end
  end

  assign sel_e = s2_q;
`else
  assign sel_e = sel;
`endif

  assign term = sel_e ? TERM_SLOW : TERM_FAST;

  // Next state: >= compare lets an over-range count (after slow->fast) resync on the next edge.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    out_d = out_q;
    if (cnt_q >= term) begin
      cnt_d = '0;
      out_d = ~out_q;
    end
  end

  // Counter and output flop; reset drops out immediately, independent of in.
  always_ff @(posedge in or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_clk_div.sv
// tb_clk_div: randomized scoreboard bench for clk_div with default ratios.
module tb_clk_div;

  localparam int HF = 1;
  localparam int HS = 4;
`ifdef CLKDIV_SEL_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic in  = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic out;

  clk_div #(.CNT_W(26), .HALF_FAST(HF), .HALF_SLOW(HS)) dut (
    .in (in),
    .rst(rst),
    .sel(sel),
    .out(out)
  );

  always #5 in = ~in;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  // Reference model: level of the output, edges spent in the current half-period,
  // and a short history of sel (for the synchronized build).
  bit m_out  = 1'b0;
  int m_run  = 0;
  bit m_h1   = 1'b0;
  bit m_h2   = 1'b0;
  int m_maxhalf = 0;

  task automatic model_reset();
    m_out = 1'b0; m_run = 0; m_h1 = 1'b0; m_h2 = 1'b0;
  endtask

  // One rising edge of in as seen by the spec: the half-period ends once it has
  // lasted the number of edges the currently effective ratio asks for.
  task automatic model_edge();
    bit se;
    int h;
    if (!rst) begin
      model_reset();
    end else begin
      se = SYNC ? m_h2 : sel;
      h  = se ? HS : HF;
      m_run = m_run + 1;
      if (m_run >= h) begin
        m_out = ~m_out;
        if (m_run > m_maxhalf) m_maxhalf = m_run;
        m_run = 0;
      end
      m_h2 = m_h1;
      m_h1 = sel;
    end
    exp_q.push_back(m_out);
  endtask

  // Drive inputs away from both edges, then account for the next rising edge.
  task automatic step(input bit s, input bit r);
    @(negedge in);
    #2;
    sel = s;
    rst = r;
    @(posedge in);
    model_edge();
  endtask

  task automatic check(input string name, input bit act, input bit req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: out=%0b expected=%0b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every falling edge, compare out against the oldest expectation.
  always @(negedge in) begin
    if (exp_q.size() > 0) check("edge", out, exp_q.pop_front());
  end

  // Asynchronous reset while out is high: out must drop without an in edge.
  task automatic pulse_reset(input bit s);
    int guard = 0;
    while (m_out != 1'b1 && guard < 20) begin
      step(s, 1'b1);
      guard++;
    end
    check("reset_guard_high", m_out, 1'b1);
    @(negedge in);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", out, 1'b0);
    model_reset();
    step(s, 1'b0);
    step(s, 1'b0);
  endtask

  initial begin
    int guard;
    #1;
    check("reset_state", out, 1'b0);

    // Reset hold with sel wiggling.
    repeat (8) step(1'($urandom_range(0, 1)), 1'b0);

    // Fast mode from release.
    repeat (12) step(1'b0, 1'b1);

    // Slow mode held from reset.
    repeat (3) step(1'b1, 1'b0);
    repeat (24) step(1'b1, 1'b1);

    // Slow -> fast with the half-period two edges in (cnt = 2).
    guard = 0;
    while (m_run != 2 && guard < 20) begin
      step(1'b1, 1'b1);
      guard++;
    end
    m_maxhalf = 0;
    repeat (10) step(1'b0, 1'b1);
    checks++;
    if (m_maxhalf > HS) begin
      errors++;
      $display("FAIL slow_to_fast_halfmax: model half=%0d limit=%0d", m_maxhalf, HS);
    end

    // Fast -> slow.
    repeat (20) step(1'b1, 1'b1);

    // Mid-run reset in slow and fast modes.
    pulse_reset(1'b1);
    repeat (12) step(1'b1, 1'b1);
    pulse_reset(1'b0);
    repeat (6) step(1'b0, 1'b1);

    // Random segments of constant select, with occasional resets.
    repeat (40) begin
      bit s;
      int len;
      s   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 9) == 0) pulse_reset(s);
      repeat (len) step(s, 1'b1);
    end

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge in);
      guard++;
    end
    @(negedge in);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
